// File: rtl/div_by_five_pkg.sv
// Shared types and helpers for the divisible-by-five residue encoder and its
// downstream detector.
package div_by_five_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    // Reduce a mod-15 accumulator (0..15) to its residue mod 5.
    function automatic logic [3:0] mod5(input logic [3:0] value);
        return value % 4'd5;
    endfunction

    // Returns (5 - r) mod 5 for a residue r in 0..4.
    function automatic logic [3:0] check_nibble(input logic [3:0] r);
        logic [3:0] c;
        case (r)
            4'd0:    c = 4'd0;
            4'd1:    c = 4'd4;
            4'd2:    c = 4'd3;
            4'd3:    c = 4'd2;
            4'd4:    c = 4'd1;
            default: c = 4'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mod15_nibble_adder.sv
// Combinational 4-bit adder with end-around carry, i.e. addition mod 15
// where 15 and 0 both represent the zero residue.
module mod15_nibble_adder
    import div_by_five_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    output logic [NIBBLE_W-1:0] sum
);

    logic [NIBBLE_W:0] raw;

    // The carry folds back in; a carry implies raw <= 30, so this never overflows.
    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sum = raw[NIBBLE_W-1:0] + {{(NIBBLE_W-1){1'b0}}, raw[NIBBLE_W]};
    end

endmodule

// File: rtl/div_by_five_encoder.sv
// Residue-code encoder: folds a payload word nibble-serially mod 15 and appends
// a check nibble making the codeword {payload, check} a multiple of 5.
module div_by_five_encoder
    import div_by_five_pkg::*;
#(
    parameter int DATA_WIDTH = 28
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH+3:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int N     = DATA_WIDTH / NIBBLE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    state_t                state;
    logic [NIBBLE_W-1:0]   acc;
    logic [NIBBLE_W-1:0]   acc_next;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] payload;

    mod15_nibble_adder u_adder (
        .a   (acc),
        .b   (shift[NIBBLE_W-1:0]),
        .sum (acc_next)
    );

    // One word in flight: accept in IDLE, fold N nibbles in ACCUM, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            shift     <= '0;
            payload   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        payload  <= in_data;
                        shift    <= in_data;
                        acc      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc   <= acc_next;
                    shift <= shift >> NIBBLE_W;
                    if (cnt == LAST_CNT) begin
                        out_data  <= {payload, check_nibble(mod5(acc_next))};
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_by_five_encoder.sv
// Self-checking bench for div_by_five_encoder: directed vectors, backpressure,
// mid-word reset, and randomized traffic against an arithmetic reference model.
module tb_div_by_five_encoder;

    localparam int DATA_WIDTH = 28;
    localparam int N          = DATA_WIDTH / 4;
    localparam int CW         = DATA_WIDTH + 4;
    localparam int NUM_RANDOM = 1000;

    logic                  clk;
    logic                  rst_n;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [CW-1:0]         out_data;
    logic                  out_valid;
    logic                  out_ready;

    int n_cmp;
    int n_err;

    div_by_five_encoder #(.DATA_WIDTH(DATA_WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: append (5 - d mod 5) mod 5 so the codeword is a multiple of 5.
    function automatic logic [CW-1:0] model(input logic [DATA_WIDTH-1:0] d);
        longint unsigned r;
        logic [3:0] c;
        r = longint'(d) % 5;
        c = 4'((5 - r) % 5);
        return {d, c};
    endfunction

    function automatic int mod5_of(input logic [CW-1:0] w);
        longint unsigned v;
        v = longint'(w);
        return int'(v % 5);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and wait (bounded) for the accepting edge.
    task automatic push(input logic [DATA_WIDTH-1:0] d, output bit ok);
        ok       = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                ok = 1'b1;
                return;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("[TB] FAIL reset_in_ready actual=%b required=1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_out_valid actual=%b required=0", out_valid);
        end
        n_cmp++;
        if (out_data !== '0) begin
            n_err++;
            $display("[TB] FAIL reset_out_data actual=%h required=0", out_data);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [DATA_WIDTH-1:0] vec [4];
        logic [CW-1:0]         req [4];
        bit ok;
        int lat;
        vec[0] = 28'h0000007; req[0] = 32'h00000073;
        vec[1] = 28'h0000004; req[1] = 32'h00000041;
        vec[2] = 28'h0000000; req[2] = 32'h00000000;
        vec[3] = 28'hFFFFFFF; req[3] = 32'hFFFFFFF0;
        for (int i = 0; i < 4; i++) begin
            push(vec[i], ok);
            wait_valid(lat);
            n_cmp++;
            if (!ok || lat !== N) begin
                n_err++;
                $display("[TB] FAIL directed_latency[%0d] actual=%0d required=%0d accepted=%0d", i, lat, N, ok);
            end
            n_cmp++;
            if (out_data !== req[i] || out_data !== model(vec[i])) begin
                n_err++;
                $display("[TB] FAIL directed_data[%0d] actual=%h required=%h", i, out_data, req[i]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL directed_release[%0d] actual in_ready=%b out_valid=%b required 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [CW-1:0] held;
        push(28'h0ABCDEF, ok);
        wait_valid(lat);
        held = out_data;
        n_cmp++;
        if (!ok || held !== model(28'h0ABCDEF)) begin
            n_err++;
            $display("[TB] FAIL bp_data actual=%h required=%h", held, model(28'h0ABCDEF));
        end
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 28'(32'h1111111 * (i + 2));
            tick();
            n_cmp++;
            if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL bp_hold[%0d] actual data=%h valid=%b in_ready=%b required %h/1/0",
                         i, out_data, out_valid, in_ready, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL bp_release actual in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        // A stray accepted pulse would have left IDLE and dropped in_ready.
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL bp_ignored actual in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_abort();
        bit ok;
        bit saw_valid;
        int lat;
        push(28'h1234567, ok);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_immediate actual in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        tick();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid) saw_valid = 1'b1;
        end
        n_cmp++;
        if (saw_valid !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL abort_no_output actual=%b required=0", saw_valid);
        end
        push(28'h0000002, ok);
        wait_valid(lat);
        n_cmp++;
        if (!ok || lat !== N || out_data !== 32'h00000023) begin
            n_err++;
            $display("[TB] FAIL abort_next_word actual=%h lat=%0d required=00000023 lat=%0d", out_data, lat, N);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [DATA_WIDTH-1:0] expq [$];
        int received;
        bit producer_done;
        received      = 0;
        producer_done = 1'b0;
        fork
            begin
                bit ok;
                logic [DATA_WIDTH-1:0] d;
                for (int i = 0; i < NUM_RANDOM; i++) begin
                    for (int g = $urandom_range(0, 3); g > 0; g--) tick();
                    d = DATA_WIDTH'($urandom);
                    if (i == 0) d = '1;
                    push(d, ok);
                    if (!ok) begin
                        n_cmp++;
                        n_err++;
                        $display("[TB] FAIL random_accept_timeout word=%0d", i);
                        break;
                    end
                    expq.push_back(d);
                end
                producer_done = 1'b1;
            end
            begin
                bit pending;
                logic [CW-1:0] cap;
                logic [DATA_WIDTH-1:0] d;
                int cycles;
                pending = 1'b0;
                cap     = '0;
                cycles  = 0;
                while (received < NUM_RANDOM && cycles < 40000) begin
                    if (pending) begin
                        received++;
                        n_cmp++;
                        if (expq.size() == 0) begin
                            n_err++;
                            $display("[TB] FAIL random_unexpected actual=%h required=none", cap);
                        end else begin
                            d = expq.pop_front();
                            if (cap !== model(d) || cap[CW-1:4] !== d || mod5_of(cap) != 0 || cap[3] !== 1'b0) begin
                                n_err++;
                                $display("[TB] FAIL random_word[%0d] actual=%h required=%h", received - 1, cap, model(d));
                            end
                        end
                    end
                    if (producer_done && expq.size() == 0 && !out_valid) break;
                    out_ready = ($urandom_range(0, 1) == 1);
                    pending   = out_valid && out_ready;
                    cap       = out_data;
                    tick();
                    cycles++;
                end
                out_ready = 1'b0;
                n_cmp++;
                if (received != NUM_RANDOM) begin
                    n_err++;
                    $display("[TB] FAIL random_count actual=%0d required=%0d", received, NUM_RANDOM);
                end
            end
        join
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_by_five_encoder.md
# div_by_five_encoder

Residue-code encoder paired with the divisible-by-five detector. It accepts a DATA_WIDTH-bit word over a valid/ready handshake and folds it nibble-serially through a mod-15 end-around-carry accumulator. It then appends a 4-bit check nibble so the emitted codeword is an exact multiple of 5. The block sits on the transmit side: a detector with BIT_WIDTH = DATA_WIDTH+4 downstream must report divisible for every codeword it produces.

## Interface

- DATA_WIDTH, 28, payload width. Must be a multiple of 4 and ≥ 4. N = DATA_WIDTH/4 nibbles.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  DATA_WIDTH  payload word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  encoder can accept a word.
- out_data  output  DATA_WIDTH+4  codeword {payload, check}; check occupies [3:0].
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts out_data.

## Operation

- Math: 16 ≡ 1 (mod 5), so {d, c} ≡ d + c (mod 5). The check nibble is c = (5 − (d mod 5)) mod 5, range 0..4. Bit 3 of the check nibble is always 0.
- The residue is computed as the sum of the nibbles mod 15, with end-around carry.
  - Per step: s = acc + nib (5 bits); acc_next = s[3:0] + s[4].
  - acc stays in 0..15, and 15 ≡ 0.
  - The final r = acc mod 5, taken on the 4-bit acc (0..15), is valid because 5 divides 15.
- FSM states (in the package enum): IDLE, ACCUM, DONE.
  - IDLE: in_ready = 1. On in_valid, latch in_data into the payload register and the shift register, clear acc, set cnt = 0, and go to ACCUM.
  - ACCUM: each cycle, add shift[3:0] into acc, shift right by 4, cnt++. After the Nth nibble is added (cnt == N−1), register out_data = {payload, c} and go to DONE.
  - DONE: out_valid = 1. When out_ready = 1, go to IDLE.
- in_ready = 1 only in IDLE. There is no overlap between words: in_valid in ACCUM or DONE is ignored, and the producer holds in_data until the handshake.
- out_data and out_valid are registered. out_data is stable while out_valid = 1 and out_ready = 0.

## Timing

- Reset values (rst_n low, effective immediately):
  - state = IDLE, acc = 0, cnt = 0, payload = 0, out_data = 0.
  - out_valid = 0, in_ready = 1. No handshake completes while rst_n is low.
- Latency: a word accepted on edge E0 produces out_valid = 1 after edge E0+N. For the default N = 7, out_valid is high 7 cycles after acceptance.
- Throughput: one word per N+2 cycles minimum (accept, N accumulate, 1 output). Each extra cycle with out_ready low adds one cycle.
- A DONE handshake on edge Ek gives in_ready = 1 after Ek. The next word is accepted at the earliest on edge Ek+1.
- Reset asserted mid-ACCUM or mid-DONE aborts the word: no output is produced for it, and the partial residue is discarded. After release, the block is in IDLE.
- Counter width is $clog2(N), with a minimum of 1 bit. cnt never wraps, because the state leaves ACCUM at N−1.

## Structure

- Package div_by_five_pkg holds:
  - NIBBLE_W = 4;
  - the state enum typedef (IDLE, ACCUM, DONE);
  - function check_nibble(r), which returns (5 − r) mod 5.
- Sub-module mod15_nibble_adder: 4-bit a, 4-bit b, 4-bit sum with end-around carry, purely combinational. The detector's serial accumulator reuses it.
- Top level: FSM, nibble shift register, payload register, acc register, cnt register, output register. The RTL is about 150–200 lines.

## Test plan

- in_data = 28'h0000007 -> out_data = 32'h00000073 (115 = 5·23). out_valid rises 7 cycles after acceptance.
- in_data = 28'h0000004 -> out_data = 32'h00000041 (65). in_data = 0 -> out_data = 0, check = 0.
- in_data = 28'hFFFFFFF -> acc ends at 15, r = 0, out_data = 32'hFFFFFFF0. This exercises the end-around carry on every step.
- Backpressure: hold out_ready = 0 for 3 cycles after out_valid. Required:
  - out_data is stable;
  - in_ready = 0;
  - in_valid pulses are ignored;
  - handshake on cycle 4; in_ready = 1 on the next cycle.
- Assert rst_n low for 1 cycle at ACCUM step 3 -> out_valid never rises for that word, in_ready = 1 immediately, and a following word 28'h0000002 yields 32'h00000023.
- 1000 random words with random valid/ready gaps -> every codeword mod 5 == 0, the payload field equals the input, the order is preserved, and the downstream detector (BIT_WIDTH = 32) reports divisible.
